// File: rtl/mem_eng_pkg.sv
// Shared encodings for the memory copy engine.
//   op_e    : command opcodes presented on the op input.
//   state_e : controller states (IDLE -> RUN -> DONE -> IDLE).
package mem_eng_pkg;

  typedef enum logic [1:0] {
    OP_FILL = 2'b00,
    OP_COPY = 2'b01,
    OP_CMP  = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Word-at-a-time FILL / COPY / COMPARE engine driving an ideal memory with
//   one write port and two combinational read ports.
//
// Parameters
//   ADDR_WIDTH : memory port address width.
//   IDX_W      : word-index width; the engine addresses 2**IDX_W words and
//                wraps index arithmetic at that boundary.
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset.
//   start, op                  : command request (sampled in IDLE) and opcode.
//   src_idx, dst_idx, len      : start word indices and word count (0 legal).
//   pat_base, pat_step         : FILL pattern, word i = base + i*step.
//   abort                      : stops a running command, suppressing that
//                                cycle's access.
//   busy, done                 : in RUN / one-cycle completion pulse.
//   err, aborted               : reserved opcode seen / command was aborted.
//   mis_cnt, first_mis         : COMPARE mismatch count and first mismatch index.
//   Waddr, Wren, Wdata         : memory write port.
//   Raddr1/2, Rden1/2, Rdata1/2: memory read ports, read data same-cycle.
module mem_copy_engine
  import mem_eng_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int IDX_W      = ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [IDX_W-1:0]      src_idx,
  input  logic [IDX_W-1:0]      dst_idx,
  input  logic [IDX_W:0]        len,
  input  logic [31:0]           pat_base,
  input  logic [31:0]           pat_step,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  aborted,
  output logic [IDX_W:0]        mis_cnt,
  output logic [IDX_W-1:0]      first_mis,
  output logic [ADDR_WIDTH-1:0] Waddr,
  output logic [ADDR_WIDTH-1:0] Raddr1,
  output logic [ADDR_WIDTH-1:0] Raddr2,
  output logic                  Wren,
  output logic                  Rden1,
  output logic                  Rden2,
  output logic [31:0]           Wdata,
  input  logic [31:0]           Rdata1,
  input  logic [31:0]           Rdata2
);

  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  op_e              op_q;
  logic [IDX_W-1:0] src_q, dst_q;
  logic [IDX_W:0]   len_q, i_q;
  logic [31:0]      acc_q, step_q;
  logic [IDX_W:0]   mis_cnt_q;
  logic [IDX_W-1:0] first_mis_q;
  logic             err_q, aborted_q;

  logic [IDX_W-1:0] idx, src_a, dst_a;
  logic             last, access, rsv_req;

  // i never exceeds len-1 <= 2**IDX_W - 1, so its low IDX_W bits are the index.
  assign idx     = i_q[IDX_W-1:0];
  assign src_a   = src_q + idx;
  assign dst_a   = dst_q + idx;
  assign last    = (i_q == (len_q - ONE));
  assign access  = (state_q == RUN) && !abort;
  assign rsv_req = (op_e'(op) == OP_RSV);

  // Controller state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (len == '0 || rsv_req) ? DONE : RUN;
      RUN:  if (abort || last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs: combinational from the registered command state, so
  // an abort suppresses the access in the very cycle it is raised.
  always_comb begin
    Wren   = 1'b0;
    Rden1  = 1'b0;
    Rden2  = 1'b0;
    Waddr  = '0;
    Raddr1 = '0;
    Raddr2 = '0;
    Wdata  = '0;
    if (access) begin
      case (op_q)
        OP_FILL: begin
          Wren  = 1'b1;
          Waddr = ADDR_WIDTH'(dst_a);
          Wdata = acc_q;
        end
        OP_COPY: begin
          Rden1  = 1'b1;
          Raddr1 = ADDR_WIDTH'(src_a);
          Wren   = 1'b1;
          Waddr  = ADDR_WIDTH'(dst_a);
          Wdata  = Rdata1;
        end
        OP_CMP: begin
          Rden1  = 1'b1;
          Raddr1 = ADDR_WIDTH'(src_a);
          Rden2  = 1'b1;
          Raddr2 = ADDR_WIDTH'(dst_a);
        end
        default: ;
      endcase
    end
  end

  // Command operands, index counter, pattern accumulator and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_FILL;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      i_q         <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      mis_cnt_q   <= '0;
      first_mis_q <= '0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q        <= op_e'(op);
            src_q       <= src_idx;
            dst_q       <= dst_idx;
            len_q       <= len;
            i_q         <= '0;
            acc_q       <= pat_base;
            step_q      <= pat_step;
            mis_cnt_q   <= '0;
            first_mis_q <= '0;
            err_q       <= rsv_req;
            aborted_q   <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            aborted_q <= 1'b1;
          end else begin
            i_q   <= i_q + ONE;
            // FILL pattern advances by addition, base + i*step without a multiply.
            acc_q <= acc_q + step_q;
            if (op_q == OP_CMP && Rdata1 != Rdata2) begin
              mis_cnt_q <= mis_cnt_q + ONE;
              if (mis_cnt_q == '0) first_mis_q <= idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign aborted   = aborted_q;
  assign mis_cnt   = mis_cnt_q;
  assign first_mis = first_mis_q;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning memory port address width, matching the ideal memory it drives.
REQ-002 SHALL have parameter IDX_W, default ADDR_WIDTH-2, meaning word-index width; MEM_WIDTH = 2**IDX_W words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a command request sampled in IDLE only.
REQ-006 SHALL have port op, input, 2: 00 FILL, 01 COPY, 10 COMPARE, 11 reserved.
REQ-007 SHALL have ports src_idx and dst_idx, input, IDX_W each, start word indices.
REQ-008 SHALL have port len, input, IDX_W+1, word count, where 0 is legal.
REQ-009 SHALL have ports pat_base and pat_step, input, 32 each, FILL pattern.
REQ-010 SHALL have port abort, input, 1, which stops the running command.
REQ-011 SHALL have outputs busy 1, done 1, err 1, aborted 1, mis_cnt IDX_W+1, first_mis IDX_W.
REQ-012 SHALL have memory-side outputs Waddr, Raddr1 and Raddr2 (ADDR_WIDTH each); Wren, Rden1 and Rden2 (1 each); and Wdata (32).
REQ-013 SHALL have memory-side inputs Rdata1 and Rdata2, 32 each, treated as combinational (same-cycle) read data.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE when start=1, latch op, src_idx, dst_idx, len and the pattern inputs, clear i, mis_cnt, first_mis, err and aborted, and go to RUN (len>0, legal op) or DONE (len=0 or op=11).
REQ-016 SHALL set err=1 on op=11 and perform no memory access.
REQ-017 SHALL ignore start outside IDLE and hold latched operands stable for the whole command.
REQ-018 SHALL, in RUN, perform one word per cycle for i = 0..len-1, then go to DONE on the cycle where i = len-1.
REQ-019 SHALL, for FILL, drive Wren=1, Waddr=dst+i and Wdata=pat_base+i*pat_step (mod 2^32), computed by an accumulator with no multiplier.
REQ-020 SHALL, for COPY, drive Rden1=1, Raddr1=src+i, Wren=1, Waddr=dst+i and Wdata=Rdata1 in the same cycle.
REQ-021 SHALL, for COMPARE, drive Rden1=1 with Raddr1=src+i, Rden2=1 with Raddr2=dst+i, and Wren=0; on Rdata1!=Rdata2, increment mis_cnt and record first_mis=i on the first mismatch only.
REQ-022 SHALL compute index arithmetic modulo MEM_WIDTH (wrap from MEM_WIDTH-1 to 0) and zero-extend it onto the ADDR_WIDTH ports.
REQ-023 SHALL NOT write-forward a COPY with overlapping ranges: each read returns pre-edge memory contents, and overlapping-range results are those of a forward word-by-word copy.
REQ-024 SHALL drive Wren, Rden1 and Rden2 to 0, and the address/data outputs to 0, in IDLE and DONE.
REQ-025 SHALL assert busy exactly while in RUN.
REQ-026 SHALL pulse done for exactly one cycle, in DONE, and then return to IDLE.
REQ-027 SHALL, on abort=1 in RUN, suppress that cycle's memory access, set aborted=1 and go to DONE; abort SHALL be ignored outside RUN.
REQ-028 SHALL give abort priority when abort and the last access coincide.
REQ-029 SHALL hold err, aborted, mis_cnt and first_mis after done until the next accepted start.

Reset
REQ-030 SHALL, on rst_n=0 at any time including mid-command, immediately go to IDLE, clear all registers and outputs to 0, and issue no partial write after deassertion.
REQ-031 SHALL synchronise rst_n deassertion at instantiation level; the block only requires the asynchronous assert.

Structure
REQ-032 SHALL place op encodings (OP_FILL, OP_COPY, OP_CMP, OP_RSV) and the state encodings in a shared package mem_eng_pkg.
REQ-033 SHALL use a single module with no sub-modules; the pattern accumulator and index counter are inline.

Verification
REQ-034 SHALL verify FILL with dst=25, len=25, base=0, step=4: mem[25..49] = 0,4,...,96; busy is high 25 cycles; done pulses on cycle 26.
REQ-035 SHALL verify COPY with src=25, dst=50, len=25 after REQ-034: mem[50..74] equals mem[25..49] and the source is unchanged.
REQ-036 SHALL verify COMPARE of [25,50) vs [50,75) with mem[60] corrupted to 0xDEADBEEF: mis_cnt=1 and first_mis=10.
REQ-037 SHALL verify wrap: FILL with dst=254, len=4, base=7, step=1 at IDX_W=8 writes mem[254]=7, mem[255]=8, mem[0]=9, mem[1]=10.
REQ-038 SHALL verify boundaries: len=0 gives done on the next cycle and no Wren; op=11 gives err=1 and no access; abort at i=3 of len=10 leaves exactly 3 words written with aborted=1.
REQ-039 SHALL verify rst_n pulsed low mid-COPY: all outputs are 0 immediately, no Wren afterwards, and start is accepted normally after release.
